calc_sequencer: RTL



---
 rtl/calc_pkg.sv | 65 ++++++
 rtl/calc_operand_accum.sv | 56 +++++
 rtl/calc_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes and sequencer states for the calculator.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package calc_pkg;

    typedef enum logic [3:0] {
        KEY_1   = 4'd0,  KEY_2 = 4'd1,  KEY_3 = 4'd2,  KEY_ADD = 4'd3,
        KEY_4   = 4'd4,  KEY_5 = 4'd5,  KEY_6 = 4'd6,  KEY_SUB = 4'd7,
        KEY_7   = 4'd8,  KEY_8 = 4'd9,  KEY_9 = 4'd10, KEY_MUL = 4'd11,
        KEY_EQ  = 4'd12, KEY_0 = 4'd13, KEY_CLR = 4'd14, KEY_NEG = 4'd15
    } key_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } alu_op_e;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        EXEC    = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } seq_state_e;

    localparam logic [15:0] ERR_DISPLAY = 16'h8000;

    function automatic logic key_is_op(input key_e k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic logic key_is_digit(input key_e k);
        return !(key_is_op(k) || (k == KEY_EQ) || (k == KEY_CLR) || (k == KEY_NEG));
    endfunction

    function automatic logic [3:0] key_digit(input key_e k);
        logic [3:0] d;
        case (k)
            KEY_1:   d = 4'd1;
            KEY_2:   d = 4'd2;
            KEY_3:   d = 4'd3;
            KEY_4:   d = 4'd4;
            KEY_5:   d = 4'd5;
            KEY_6:   d = 4'd6;
            KEY_7:   d = 4'd7;
            KEY_8:   d = 4'd8;
            KEY_9:   d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic alu_op_e key_op(input key_e k);
        alu_op_e op;
        case (k)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_operand_accum.sv
// Decimal operand builder: sign, magnitude, digit count, x10 accumulate with limit.
// Latency: one cycle from a digit/neg strobe to the updated value.
// Backpressure: none; every strobe is applied or dropped in the same cycle.
module calc_operand_accum #(
    parameter int DIGIT_LIMIT = 32767
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        clr,
    input  logic        dig_vld,
    input  logic [3:0]  dig,
    input  logic        neg_vld,
    output logic [15:0] value
);

    localparam logic [19:0] LIMIT = 20'(DIGIT_LIMIT);

    logic [15:0] mag;
    logic        neg;
    logic [2:0]  cnt;

    logic [15:0] base_mag;
    logic        base_neg;
    logic [2:0]  base_cnt;
    logic [19:0] prod;

    // A clear in the same cycle as a digit starts a fresh operand with that digit.
    always_comb begin
        base_mag = clr ? 16'd0 : mag;
        base_neg = clr ? 1'b0  : neg;
        base_cnt = clr ? 3'd0  : cnt;
        prod     = {4'd0, base_mag} * 20'd10 + {16'd0, dig};
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mag <= 16'd0;
            neg <= 1'b0;
            cnt <= 3'd0;
        end else begin
            mag <= base_mag;
            neg <= base_neg;
            cnt <= base_cnt;
            if (dig_vld && (prod <= LIMIT)) begin
                mag <= prod[15:0];
                if (base_cnt != 3'd7)
                    cnt <= base_cnt + 3'd1;
            end
            if (neg_vld && (base_cnt == 3'd0))
                neg <= ~base_neg;
        end
    end

    assign value = neg ? (16'd0 - mag) : mag;

endmodule

// File: rtl/calc_sequencer.sv
// Key-driven operand/operator sequencer owning the single start/done path to the ALU.
// Latency: key acked one edge after key_valid seen, applied the next edge; ALU result flagged one edge after alu_done.
// Backpressure: key_valid is left pending (no key_read) while in EXEC or WAIT.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGIT_LIMIT = 32767
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        key_valid,
    input  logic [3:0]  key_index,
    output logic        key_read,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_ovf,
    output logic [15:0] display_output,
    output logic        complete,
    output logic        error
);

    seq_state_e  state, state_nxt;
    key_e        key_q;
    alu_op_e     op_reg;
    logic [15:0] a_reg, b_reg, res_reg, acc_value;
    logic        b_touched;
    logic        done_q, done_ovf;
    logic [15:0] done_res;

    logic acc_clr, acc_dig_vld, acc_neg_vld;
    logic clr_all, latch_a, chain_a, latch_op, latch_b, latch_res;
    logic b_touch_set, b_touch_clr, is_dig, is_op, key_accept;

    calc_operand_accum #(.DIGIT_LIMIT(DIGIT_LIMIT)) u_accum (
        .clk     (clk),
        .nRST    (nRST),
        .clr     (acc_clr),
        .dig_vld (acc_dig_vld),
        .dig     (key_digit(key_q)),
        .neg_vld (acc_neg_vld),
        .value   (acc_value)
    );

    assign key_accept = key_valid && !key_read && (state != EXEC) && (state != WAIT);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= ENTRY_A;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        acc_clr     = 1'b0;
        acc_dig_vld = 1'b0;
        acc_neg_vld = 1'b0;
        clr_all     = 1'b0;
        latch_a     = 1'b0;
        chain_a     = 1'b0;
        latch_op    = 1'b0;
        latch_b     = 1'b0;
        latch_res   = 1'b0;
        b_touch_set = 1'b0;
        b_touch_clr = 1'b0;
        is_dig      = key_is_digit(key_q);
        is_op       = key_is_op(key_q);
        case (state)
            ENTRY_A: if (key_read) begin
                if (key_q == KEY_CLR)      clr_all = 1'b1;
                else if (is_dig)           acc_dig_vld = 1'b1;
                else if (key_q == KEY_NEG) acc_neg_vld = 1'b1;
                else if (is_op) begin
                    latch_a     = 1'b1;
                    latch_op    = 1'b1;
                    acc_clr     = 1'b1;
                    b_touch_clr = 1'b1;
                    state_nxt   = ENTRY_B;
                end
            end
            ENTRY_B: if (key_read) begin
                if (key_q == KEY_CLR) clr_all = 1'b1;
                else if (is_dig) begin
                    acc_dig_vld = 1'b1;
                    b_touch_set = 1'b1;
                end else if (key_q == KEY_NEG) begin
                    acc_neg_vld = 1'b1;
                    b_touch_set = 1'b1;
                end else if (is_op) latch_op = 1'b1;
                else if (key_q == KEY_EQ) begin
                    latch_b   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = WAIT;
            WAIT: if (done_q) begin
                latch_res = 1'b1;
                state_nxt = done_ovf ? ERR : DONE;
            end
            DONE: if (key_read) begin
                if (key_q == KEY_CLR) clr_all = 1'b1;
                else if (is_dig) begin
                    clr_all     = 1'b1;
                    acc_dig_vld = 1'b1;
                end else if (is_op) begin
                    chain_a     = 1'b1;
                    latch_op    = 1'b1;
                    acc_clr     = 1'b1;
                    b_touch_clr = 1'b1;
                    state_nxt   = ENTRY_B;
                end
            end
            ERR: if (key_read && (key_q == KEY_CLR)) clr_all = 1'b1;
            default: state_nxt = ENTRY_A;
        endcase
        if (clr_all) begin
            acc_clr   = 1'b1;
            state_nxt = ENTRY_A;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            key_read  <= 1'b0;
            key_q     <= KEY_1;
            a_reg     <= 16'd0;
            b_reg     <= 16'd0;
            res_reg   <= 16'd0;
            op_reg    <= OP_ADD;
            b_touched <= 1'b0;
            done_q    <= 1'b0;
            done_ovf  <= 1'b0;
            done_res  <= 16'd0;
        end else begin
            key_read <= key_accept;
            if (key_accept)
                key_q <= key_e'(key_index);
            // Result strobes are only meaningful while a transaction is outstanding.
            done_q   <= alu_done && (state == WAIT);
            done_ovf <= alu_ovf;
            done_res <= alu_result;
            if (clr_all) begin
                a_reg   <= 16'd0;
                b_reg   <= 16'd0;
                res_reg <= 16'd0;
                op_reg  <= OP_ADD;
            end else begin
                if (latch_a)   a_reg   <= acc_value;
                if (chain_a)   a_reg   <= res_reg;
                if (latch_op)  op_reg  <= key_op(key_q);
                if (latch_b)   b_reg   <= acc_value;
                if (latch_res) res_reg <= done_res;
            end
            if (b_touch_clr || clr_all) b_touched <= 1'b0;
            else if (b_touch_set)       b_touched <= 1'b1;
        end
    end

    always_comb begin
        display_output = 16'd0;
        case (state)
            ENTRY_A:    display_output = acc_value;
            ENTRY_B:    display_output = b_touched ? acc_value : a_reg;
            EXEC, WAIT: display_output = b_reg;
            DONE:       display_output = res_reg;
            ERR:        display_output = ERR_DISPLAY;
            default:    display_output = 16'd0;
        endcase
    end

    assign alu_start = (state == EXEC);
    assign alu_op    = op_reg;
    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign complete  = (state == DONE);
    assign error     = (state == ERR);

endmodule
